// File: rtl/cache_fill_arbiter_if.sv
// cache_fill_arbiter_if: request, memory and fill-side signals of the block-fill arbiter
//   master: arbiter side (takes miss/store requests and read returns, drives memory and fill strobes)
//   slave : environment side (caches, pipeline, memory)
interface cache_fill_arbiter_if #(parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic              i_miss_req;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss_req;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_we_i;
  logic              fill_we_d;
  logic [2:0]        fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              fill_done_i;
  logic              fill_done_d;
  logic              d_wr_ack;
  logic              stall_i;
  logic              stall_d;
  modport master (
    input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_valid, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_we_i, fill_we_d, fill_idx, fill_data,
           fill_done_i, fill_done_d, d_wr_ack, stall_i, stall_d
  );
  modport slave (
    output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
           mem_valid, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_we_i, fill_we_d, fill_idx, fill_data,
           fill_done_i, fill_done_d, d_wr_ack, stall_i, stall_d
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares main memory between I/D block fills and D write-through stores
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requests, memory port, fill strobes and stalls (cache_fill_arbiter_if.master)
module cache_fill_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input logic clk,
  input logic rst_n,
  cache_fill_arbiter_if.master bus
);
  localparam int IW = $clog2(WORDS + 1);
  localparam int RW = $clog2(WORDS);
  if (WORDS != 8 || DATA_W != 16 || MEM_LAT < 1) begin : g_bad_cfg
    $error("cache_fill_arbiter: block must be 8 x 16-bit words and MEM_LAT >= 1");
  end
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t            r_state;
  logic              r_owner;
  logic [ADDR_W-1:0] r_base;
  logic [IW-1:0]     r_issue_cnt;
  logic [RW-1:0]     r_ret_cnt;
  logic              w_idle, w_fill, w_done, w_wr, w_issue, w_ret;
  logic [ADDR_W-1:0] w_miss_addr;
  // Qualifying with rst_n forces every output low while reset is held.
  always_comb begin
    w_idle      = rst_n && r_state == IDLE;
    w_fill      = rst_n && r_state == FILL;
    w_done      = rst_n && r_state == DONE;
    w_wr        = w_idle && bus.d_wr_req;
    w_issue     = w_fill && r_issue_cnt < IW'(WORDS);
    w_ret       = w_fill && bus.mem_valid;
    w_miss_addr = bus.d_miss_req ? bus.d_miss_addr : bus.i_miss_addr;
  end
  assign bus.mem_en      = w_wr | w_issue;
  assign bus.mem_wr      = w_wr;
  assign bus.mem_addr    = w_wr ? bus.d_wr_addr : w_issue ? r_base + (ADDR_W'(r_issue_cnt) << 1) : '0;
  assign bus.mem_wdata   = w_wr ? bus.d_wr_data : '0;
  assign bus.fill_we_i   = w_ret & ~r_owner;
  assign bus.fill_we_d   = w_ret & r_owner;
  assign bus.fill_idx    = w_ret ? r_ret_cnt : '0;
  assign bus.fill_data   = w_ret ? bus.mem_rdata : '0;
  assign bus.fill_done_i = w_done & ~r_owner;
  assign bus.fill_done_d = w_done & r_owner;
  assign bus.d_wr_ack    = w_wr;
  assign bus.stall_i     = rst_n & bus.i_miss_req & ~bus.fill_done_i;
  assign bus.stall_d     = rst_n & ((bus.d_miss_req & ~bus.fill_done_d) | (bus.d_wr_req & ~bus.d_wr_ack));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (!bus.d_wr_req && (bus.d_miss_req || bus.i_miss_req)) begin
          r_state     <= FILL;
          r_owner     <= bus.d_miss_req;
          r_base      <= {w_miss_addr[ADDR_W-1:4], 4'b0};
          r_issue_cnt <= '0;
          r_ret_cnt   <= '0;
        end
        FILL: begin
          if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
          if (bus.mem_valid) begin
            r_ret_cnt <= r_ret_cnt + 1'b1;
            if (r_ret_cnt == RW'(WORDS - 1)) r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Shares the single-port, multi-cycle main memory between the instruction-cache miss path, the data-cache miss path and the data-side write-through path. On a miss it sequences a full block fill: it issues the word reads back-to-back, counts the returned words, and steers each one into the requesting cache. It also raises per-side stall requests, which the pipeline ORs with the load-use stall from `hazard_forward`.

## Interface
- `ADDR_W`, 16, byte-address width
- `DATA_W`, 16, memory word width
- `WORDS`, 8, words per cache block (block = 16 bytes)
- `MEM_LAT`, 4, memory read latency in cycles (issue to `mem_valid`); used only by the bench

- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock; asynchronous, active-low
- `i_miss_req`  in  1  I-cache miss; held high until `fill_done_i`
- `i_miss_addr`  in  ADDR_W  I-side miss byte address
- `d_miss_req`  in  1  D-cache miss; held high until `fill_done_d`
- `d_miss_addr`  in  ADDR_W  D-side miss byte address
- `d_wr_req`  in  1  write-through store request; held until `d_wr_ack`
- `d_wr_addr`  in  ADDR_W  store byte address
- `d_wr_data`  in  DATA_W  store data
- `mem_en`  out  1  memory access this cycle
- `mem_wr`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_W  memory byte address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_valid`  in  1  read data valid
- `mem_rdata`  in  DATA_W  read data
- `fill_we_i`, `fill_we_d`  out  1  write returned word into I / D cache array
- `fill_idx`  out  3  word index within the block being filled
- `fill_data`  out  DATA_W  the returned word (equals `mem_rdata`)
- `fill_done_i`, `fill_done_d`  out  1  one-cycle pulse: block complete
- `d_wr_ack`  out  1  one-cycle pulse: store issued
- `stall_i`, `stall_d`  out  1  stall requests to the pipeline

## Operation
- FSM states: IDLE, FILL, DONE. A 1-bit `owner` register records the side being filled (0 = I, 1 = D).
- Registers: `issue_cnt` (0..WORDS) and `ret_cnt` (0..WORDS-1).
- Block base = miss address with bits [3:0] cleared. Base is latched on entering FILL.
- Word k address = base + 2k. Addition is ADDR_W bits and wraps modulo 2^ADDR_W.
- IDLE priority is fixed: `d_wr_req` > `d_miss_req` > `i_miss_req`.
- IDLE with `d_wr_req`:
  - Drive `mem_en=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_wdata=d_wr_data`, `d_wr_ack=1` in the same cycle.
  - Stay in IDLE. A pending miss is taken on the next cycle.
- IDLE with a miss and no write: latch base and `owner`, clear both counters, go to FILL.
- FILL, issue side:
  - While `issue_cnt < WORDS`: `mem_en=1`, `mem_wr=0`, `mem_addr=base+2*issue_cnt`, then increment `issue_cnt`.
  - Once `issue_cnt == WORDS`, `mem_en=0`.
- FILL, return side, on each `mem_valid`:
  - Assert `fill_we_<owner>`, with `fill_idx=ret_cnt` and `fill_data=mem_rdata`.
  - Increment `ret_cnt`.
  - If `ret_cnt == WORDS-1`, go to DONE.
- DONE: pulse `fill_done_<owner>` for one cycle, then go to IDLE.
- Requests and writes during FILL or DONE are not granted; `d_wr_req` waits.
- A request deasserting mid-fill is a protocol error. The fill still completes and `fill_done` still pulses.
- `mem_valid` outside FILL is ignored: no `fill_we`, no counter change.
- `stall_i = i_miss_req & ~fill_done_i`.
- `stall_d = (d_miss_req & ~fill_done_d) | (d_wr_req & ~d_wr_ack)`.
- Reset (asynchronous, at any time including mid-fill): state IDLE, counters 0, `owner` 0, base 0.
  - Every output is 0 while reset is asserted and in IDLE with no requests pending.
  - After reset, in-flight memory returns are ignored because the state is IDLE.

## Timing
- Miss first seen in IDLE at cycle 0:
  - FILL from cycle 1; reads issued cycles 1..8.
  - With `MEM_LAT=4`, returns arrive cycles 5..12; `fill_we` is asserted those cycles.
  - DONE and `fill_done` at cycle 13; IDLE at cycle 14.
  - Total miss penalty is 14 cycles.
- `fill_we_*`, `fill_data`, `fill_done_*` and `d_wr_ack` are combinational from state, counters and `mem_valid`. There is no added latency.
- Back-to-back: an I miss waiting behind a D fill enters FILL the cycle after that D fill's DONE, unless a write is pending, which goes first.
- A store is acknowledged in its request cycle when the FSM is in IDLE.

## Test plan
- Reset, then idle with no requests -> all outputs 0.
- `i_miss_req`, `i_miss_addr=0x1236`:
  - `mem_addr` = 0x1230, 0x1232, … 0x123E on cycles 1–8.
  - `fill_we_i` with `fill_idx` 0..7 on cycles 5–12.
  - `fill_done_i` at cycle 13; `stall_i` high cycles 0–12.
- `d_miss_req` and `i_miss_req` raised in the same cycle:
  - D block filled first, `fill_done_d` at cycle 13.
  - I block issue starts at cycle 15, `fill_done_i` at cycle 27.
- `d_wr_req` (0x0040, 0xBEEF) raised while an I fill is at cycle 3:
  - No write during the fill.
  - Write issues on the IDLE cycle after DONE with `mem_wr=1` and `d_wr_ack`.
  - `stall_d` high throughout the wait.
- Miss at `i_miss_addr=0xFFFA` -> base 0xFFF0, addresses 0xFFF0..0xFFFE.
- `rst_n` pulsed low during FILL at `ret_cnt=3`:
  - State returns to IDLE and all outputs drop to 0 immediately.
  - Later `mem_valid` pulses produce no `fill_we`.
  - A re-raised miss restarts from word 0.
